// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types, helpers and parameter checks for sync_fifo_flags
//
// Contents:
//   fifo_mode_e        read-port mode (registered or first-word fall-through)
//   clog2_depth        ceiling log2 used to size memory addresses
//   FIFO_CHECK_PARAMS  elaboration-time threshold legality check
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Threshold check, expanded inside the module body as a labelled generate-if.
`define FIFO_CHECK_PARAMS(depth, afull, aempty) \
  if (((afull) < 1) || ((afull) > (depth)) || ((aempty) < 0) || \
      ((aempty) > ((depth) - 1)) || ((aempty) >= (afull))) begin : g_bad_params \
    $error("sync_fifo_flags: illegal AFULL_TH/AEMPTY_TH for this depth"); \
  end

package fifo_pkg;

  typedef enum logic {
    MODE_REG  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < depth) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_flags_mem.sv
// rtl/sync_fifo_flags_mem.sv - simple dual-port storage array for sync_fifo_flags
//
// Module fifo_mem: DSIZE x DEPTH array, one synchronous write port, one read port.
// Ports:
//   clk, rst      clock and synchronous active-high reset (read register only)
//   we, waddr     write enable and address
//   wdata         write data
//   re, raddr     read enable (registered mode only) and read address
//   rdata         read data: registered on re (FWFT=0) or combinational (FWFT=1)
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [clog2_depth(DEPTH)-1:0]  waddr,
  input  logic [DSIZE-1:0]               wdata,
  input  logic                           re,
  input  logic [clog2_depth(DEPTH)-1:0]  raddr,
  output logic [DSIZE-1:0]               rdata
);

  // Storage is deliberately not reset so the array maps onto block RAM.
  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (FWFT == int'(MODE_FWFT)) begin : g_fwft
    // Head word is presented continuously; rst and re have no role here.
    logic unused_fwft;
    assign unused_fwft = &{1'b0, rst, re};
    assign rdata = mem[raddr];
  end else begin : g_reg
    logic [DSIZE-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= mem[raddr];
    end
    assign rdata = rdata_q;
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, thresholds, sticky errors and flush
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wdata, winc         write data and write request
//   rinc                read/pop request
//   flush               synchronous clear of contents (errors and rdata kept)
//   err_clr             clears overflow/underflow
//   rdata               read data (registered or FWFT, per FWFT parameter)
//   wfull, rempty       full / empty
//   almost_full         count >= AFULL_TH
//   almost_empty        count <= AEMPTY_TH
//   count               occupancy 0..DEPTH
//   overflow, underflow sticky write-while-full / read-while-empty
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 1,
  parameter int FWFT      = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             flush,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_C  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_C  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_C = (ASIZE+1)'(AEMPTY_TH);

  `FIFO_CHECK_PARAMS(DEPTH, AFULL_TH, AEMPTY_TH)

  logic [ASIZE:0] wbin, rbin;
  logic [ASIZE:0] wbin_next, rbin_next, count_next;
  logic           wr_ok, rd_ok;
  logic           mem_we, mem_re;

  // Full rejects the write even when a read frees a slot in the same cycle,
  // and empty rejects the read even when a write lands in the same cycle.
  assign wr_ok = winc & ~wfull;
  assign rd_ok = rinc & ~rempty;

  assign wbin_next = wbin + {{ASIZE{1'b0}}, wr_ok};
  assign rbin_next = rbin + {{ASIZE{1'b0}}, rd_ok};

  // Pointers carry one extra MSB, so their modulo-2*DEPTH difference is the
  // exact occupancy 0..DEPTH across any number of wraps.
  assign count_next = wbin_next - rbin_next;

  assign mem_we = wr_ok & ~flush & ~rst;
  assign mem_re = rd_ok & ~flush & ~rst;

  fifo_mem #(
    .DSIZE (DSIZE),
    .DEPTH (DEPTH),
    .FWFT  (FWFT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wbin[ASIZE-1:0]),
    .wdata (wdata),
    .re    (mem_re),
    .raddr (rbin[ASIZE-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin         <= '0;
      rbin         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      // Error flags are left untouched: they record history, not contents.
      wbin         <= '0;
      rbin         <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wbin         <= wbin_next;
      rbin         <= rbin_next;
      count        <= count_next;
      wfull        <= (count_next == DEPTH_C);
      rempty       <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_C);
      almost_empty <= (count_next <= AEMPTY_C);
      // A new error in the same cycle as err_clr keeps the flag set.
      overflow     <= (winc & wfull)  | (overflow  & ~err_clr);
      underflow    <= (rinc & rempty) | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags in both read modes
module tb_sync_fifo_flags;

  logic        clk = 1'b0;
  logic        rst, winc, rinc, flush, err_clr;
  logic [31:0] wdata;

  logic [31:0] rdata_r, rdata_f;
  logic        wfull_r, rempty_r, afull_r, aempty_r, ovf_r, unf_r;
  logic        wfull_f, rempty_f, afull_f, aempty_f, ovf_f, unf_f;
  logic [3:0]  count_r, count_f;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [31:0] sb[$];
  int          mcnt  = 0;
  logic        movf  = 1'b0;
  logic        mund  = 1'b0;
  logic [31:0] mlast = 32'h0;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .DSIZE(32), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(0)
  ) u_reg (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
    .flush(flush), .err_clr(err_clr), .rdata(rdata_r), .wfull(wfull_r),
    .rempty(rempty_r), .almost_full(afull_r), .almost_empty(aempty_r),
    .count(count_r), .overflow(ovf_r), .underflow(unf_r)
  );

  sync_fifo_flags #(
    .DSIZE(32), .ASIZE(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc),
    .flush(flush), .err_clr(err_clr), .rdata(rdata_f), .wfull(wfull_f),
    .rempty(rempty_f), .almost_full(afull_f), .almost_empty(aempty_f),
    .count(count_f), .overflow(ovf_f), .underflow(unf_f)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":reg.count"},   count_r,  mcnt);
    chk({tag, ":fwft.count"},  count_f,  mcnt);
    chk({tag, ":reg.wfull"},   wfull_r,  mcnt == 8);
    chk({tag, ":fwft.wfull"},  wfull_f,  mcnt == 8);
    chk({tag, ":reg.rempty"},  rempty_r, mcnt == 0);
    chk({tag, ":fwft.rempty"}, rempty_f, mcnt == 0);
    chk({tag, ":reg.afull"},   afull_r,  mcnt >= 6);
    chk({tag, ":fwft.afull"},  afull_f,  mcnt >= 6);
    chk({tag, ":reg.aempty"},  aempty_r, mcnt <= 1);
    chk({tag, ":fwft.aempty"}, aempty_f, mcnt <= 1);
    chk({tag, ":reg.ovf"},     ovf_r,    movf);
    chk({tag, ":fwft.ovf"},    ovf_f,    movf);
    chk({tag, ":reg.unf"},     unf_r,    mund);
    chk({tag, ":fwft.unf"},    unf_f,    mund);
  endtask

  // One clock of traffic; the popped word is compared on the FWFT instance
  // before the edge and on the registered instance after it.
  task automatic cycle(input logic w, input logic [31:0] d, input logic r);
    logic        wok, rok;
    logic [31:0] exp;
    exp   = 32'h0;
    winc  = w;
    wdata = d;
    rinc  = r;
    wok   = w && (mcnt < 8);
    rok   = r && (mcnt > 0);
    if (w && mcnt == 8) movf = 1'b1;
    if (r && mcnt == 0) mund = 1'b1;
    if (rok) begin
      exp = sb.pop_front();
      chk("fwft.rdata", rdata_f, exp);
      mlast = exp;
    end
    if (wok) sb.push_back(d);
    mcnt = mcnt + int'(wok) - int'(rok);
    @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
    if (rok) chk("reg.rdata", rdata_r, exp);
  endtask

  task automatic do_flush(input logic w, input logic [31:0] d);
    flush = 1'b1;
    winc  = w;
    wdata = d;
    @(posedge clk);
    #1;
    flush = 1'b0;
    winc  = 1'b0;
    mcnt  = 0;
    sb.delete();
  endtask

  task automatic do_err_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    movf = 1'b0;
    mund = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    winc = 1'b0; rinc = 1'b0; flush = 1'b0; err_clr = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    mcnt  = 0;
    movf  = 1'b0;
    mund  = 1'b0;
    mlast = 32'h0;
    sb.delete();
  endtask

  initial begin
    logic [31:0] p;
    rst = 1'b1; winc = 1'b0; rinc = 1'b0; flush = 1'b0; err_clr = 1'b0; wdata = '0;
    @(posedge clk);
    do_reset();
    check_state("reset");
    chk("reset.reg.rdata", rdata_r, 32'h0);

    // Fill and drain
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 32'(i * 32'h11), 1'b0);
      check_state("fill");
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check_state("drain");
    end

    // FWFT latency
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    chk("fwft.latency.rempty", rempty_f, 1'b0);
    chk("fwft.latency.rdata", rdata_f, 32'hDEADBEEF);
    cycle(1'b0, 32'h0, 1'b1);
    check_state("fwft.pop");

    // Full with simultaneous write and read
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'hA0 + 32'(i), 1'b0);
    check_state("full");
    cycle(1'b1, 32'h5555, 1'b1);
    check_state("full.wr_rd");
    for (int i = 0; i < 7; i++) cycle(1'b0, 32'h0, 1'b1);
    check_state("full.drained");

    // Empty with simultaneous write and read
    cycle(1'b1, 32'h77, 1'b1);
    check_state("empty.wr_rd");
    cycle(1'b0, 32'h0, 1'b1);
    do_err_clr();
    check_state("err_clr");

    // Wrap: 5 preloaded, then 20 write/read pairs
    p = 32'h100;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, p, 1'b0);
      p++;
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, p, 1'b1);
      p++;
      check_state("wrap");
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
    check_state("wrap.drained");

    // Flush with a concurrent write
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hF0 + 32'(i), 1'b0);
    check_state("preflush");
    do_flush(1'b1, 32'hBAD0BAD0);
    check_state("flush");
    chk("flush.reg.rdata_hold", rdata_r, mlast);
    cycle(1'b1, 32'h1234, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check_state("postflush");

    // Reset mid-operation with count=5 and overflow set
    for (int i = 0; i < 8; i++) cycle(1'b1, 32'hC0 + 32'(i), 1'b0);
    cycle(1'b1, 32'hEEEE, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
    check_state("prereset");
    do_reset();
    check_state("midreset");
    chk("midreset.reg.rdata", rdata_r, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
